countdown_arbiter: RTL and testbench
====================================

COUNTDOWN_ARBITER -- requirements
Module: countdown_arbiter

Interface
REQ-001 Parameter: dw, default 8, width of count and load values.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-low reset: 0 resets, 1 runs.
REQ-004 Port: req  input  2  per-requester request for the shared down-counter; level, held until done or abandoned.
REQ-005 Port: load_val0  input  dw  start count for requester 0; sampled at grant.
REQ-006 Port: load_val1  input  dw  start count for requester 1; sampled at grant.
REQ-007 Port: hold  input  1  owner pause; 1 freezes count during COUNT.
REQ-008 Port: grant  output  2  one-hot owner of counter; all-zero when idle.
REQ-009 Port: count  output  dw  current counter value.
REQ-010 Port: busy  output  1  1 whenever state is not IDLE.
REQ-011 Port: done  output  2  one-cycle completion pulse to owner.

Function
REQ-012 The block SHALL implement a registered FSM with states IDLE, COUNT, DONE.
REQ-013 IDLE with req==0: no change; grant=0, done=0, count holds last value.
REQ-014 IDLE with req!=0: next edge selects the winner, sets grant one-hot, loads count with that winner's load_val, and enters COUNT.
REQ-015 Winner selection: single requester wins outright; if both request, the one indicated by the round-robin pointer rr (0 or 1) wins.
REQ-016 rr SHALL update to the non-owner on every exit from COUNT or DONE to IDLE, whether by completion or by abandonment.
REQ-017 COUNT, req[owner]==1, hold==0, count!=0: count decrements by 1 each edge.
REQ-018 COUNT, hold==1: count holds; hold SHALL NOT block the count==0 transition of REQ-019.
REQ-019 COUNT, req[owner]==1, count==0: next edge enters DONE; count stays 0 and never wraps to all-ones.
REQ-020 DONE: done[owner]=1 for exactly this one cycle; grant stays asserted; next edge enters IDLE with grant=0.
REQ-021 Abandon: COUNT with req[owner]==0: next edge enters IDLE, grant=0, no done pulse, count holds its value.
REQ-022 Latency: with hold==0 and load value N, done rises exactly N+1 cycles after grant rises; N=0 gives done 1 cycle after grant.
REQ-023 Back-to-back: a request pending at the DONE->IDLE edge SHALL be granted on the following edge (one IDLE cycle minimum between owners).
REQ-024 Requests from the non-owner during COUNT/DONE SHALL be ignored, never preempt.
REQ-025 All outputs SHALL be driven from registers or decoded from registered state only; no combinational input-to-output path.
REQ-026 grant SHALL never have more than one bit set; done SHALL be set only on the grant bit.

Reset
REQ-027 reset==0 SHALL immediately, without a clock edge, force state=IDLE, grant=0, done=0, busy=0, count=0, rr=0.
REQ-028 Reset asserted mid-COUNT or DONE SHALL abort without a done pulse; first grant after release follows REQ-014 with rr=0.

Verification
REQ-029 Reset, req=01, load_val0=3, hold=0 -> grant=01 at edge 1, count 3,2,1,0, done=01 one cycle at edge 5, grant=00 at edge 6.
REQ-030 req=11 held from reset release, load_val0=1, load_val1=2 -> requester 0 served first, done=01; then grant=10 after one IDLE cycle, done=10 three cycles after its grant.
REQ-031 req=10, load_val1=0 -> grant=10, next edge done=10, next edge idle; count stays 0 and never shows FF.
REQ-032 req=01, load_val0=5, hold=1 for 3 cycles after count=3 -> count holds 3 for 3 cycles, done delayed by exactly 3 cycles versus no hold.
REQ-033 req=01, load_val0=8, drop req0 at count=4 -> IDLE next edge, no done, count=4 held; a pending req1 is granted next, rr=0 afterwards.
REQ-034 Assert reset low at count=2 mid-COUNT, between clock edges -> outputs zero at once; after release req=11 grants requester 0.

Source files
------------

// File: rtl/countdown_arbiter.sv
// countdown_arbiter
//   Two requesters share one down-counter. An idle arbiter grants the
//   counter to a single requester, or to the requester named by the
//   round-robin pointer when both ask. The granted value is loaded into the
//   counter. The counter then counts down to zero. A one-cycle done pulse
//   goes to the owner, and the counter returns to idle. If the owner drops
//   its request while counting, it abandons the counter and gets no done
//   pulse.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low (0 resets, 1 runs)
//   req[1:0]   per-requester request level
//   load_val0  start count for requester 0, sampled at grant
//   load_val1  start count for requester 1, sampled at grant
//   hold       freezes the count while counting (never blocks the zero exit)
//   grant[1:0] one-hot owner, zero when idle
//   count      current counter value
//   busy       high whenever not idle
//   done[1:0]  one-cycle completion pulse on the owner's bit
module countdown_arbiter #(
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [dw-1:0] load_val0,
  input  logic [dw-1:0] load_val1,
  input  logic          hold,
  output logic [1:0]    grant,
  output logic [dw-1:0] count,
  output logic          busy,
  output logic [1:0]    done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [dw-1:0] ONE = {{(dw-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          rr_q, rr_d;
  logic [dw-1:0] count_q, count_d;
  logic          win;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      count_q <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    count_d = count_q;
    win     = (req == 2'b11) ? rr_q : req[1];
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          owner_d = win;
          count_d = win ? load_val1 : load_val0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        // Abandonment wins over everything. The zero check comes before
        // hold, so a paused owner still completes at zero. The counter
        // never wraps below zero.
        if (!req[owner_q]) begin
          state_d = IDLE;
          rr_d    = ~owner_q;
        end else if (count_q == '0) begin
          state_d = DONE;
        end else if (!hold) begin
          count_d = count_q - ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        rr_d    = ~owner_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    busy  = (state_q != IDLE);
    grant = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    done  = (state_q == DONE) ? grant : 2'b00;
    count = count_q;
  end

endmodule

// File: tb/tb_countdown_arbiter.sv
// Scoreboard bench for countdown_arbiter. For each cycle, the stimulus
// process steps a transaction-level reference model (owner, remaining
// count, finishing flag) and queues the outputs it expects after the next
// rising edge. The monitor pops one entry shortly after each rising edge
// and compares it with the DUT.
module tb_countdown_arbiter;
  localparam int DW = 8;

  typedef struct packed {
    logic [1:0]    grant;
    logic [1:0]    done;
    logic          busy;
    logic [DW-1:0] count;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req;
  logic [DW-1:0] lv0, lv1;
  logic          hold;
  logic [1:0]    grant, done;
  logic [DW-1:0] count;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int cycno  = 0;

  exp_t q[$];

  // Reference model: -1 means no owner
  int m_owner = -1;
  int m_cnt   = 0;
  int m_rr    = 0;
  bit m_fin   = 1'b0;

  always #5 clk = ~clk;

  countdown_arbiter #(.dw(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .load_val0(lv0),
    .load_val1(lv1),
    .hold     (hold),
    .grant    (grant),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  task automatic step_model();
    if (!reset) begin
      m_owner = -1; m_fin = 1'b0; m_cnt = 0; m_rr = 0;
    end else if (m_owner < 0) begin
      if (req != 2'b00) begin
        if (req == 2'b11) m_owner = m_rr;
        else              m_owner = req[0] ? 0 : 1;
        m_cnt = (m_owner == 0) ? int'(lv0) : int'(lv1);
        m_fin = 1'b0;
      end
    end else if (m_fin) begin
      m_rr = 1 - m_owner; m_owner = -1; m_fin = 1'b0;
    end else if (!req[m_owner]) begin
      m_rr = 1 - m_owner; m_owner = -1;
    end else if (m_cnt == 0) begin
      m_fin = 1'b1;
    end else if (!hold) begin
      m_cnt = m_cnt - 1;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.grant = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    e.done  = m_fin ? e.grant : 2'b00;
    e.busy  = (m_owner >= 0);
    e.count = m_cnt[DW-1:0];
    return e;
  endfunction

  task automatic cycr(input logic rst, input logic [1:0] r, input logic h,
                      input int l0, input int l1);
    @(negedge clk);
    reset = rst; req = r; hold = h;
    lv0 = l0[DW-1:0]; lv1 = l1[DW-1:0];
    step_model();
    q.push_back(model_out());
  endtask

  task automatic cyc(input logic [1:0] r, input logic h, input int l0, input int l1);
    cycr(1'b1, r, h, l0, l1);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({grant, done, busy, count} != '0) begin
      errors++;
      $display("FAIL %s got grant=%b done=%b busy=%b count=%0d want all zero",
               name, grant, done, busy, count);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycno++;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (grant !== e.grant || done !== e.done || busy !== e.busy || count !== e.count) begin
          errors++;
          $display("FAIL out@%0d got grant=%b done=%b busy=%b count=%0d want grant=%b done=%b busy=%b count=%0d",
                   cycno, grant, done, busy, count, e.grant, e.done, e.busy, e.count);
        end
      end
    end
  end

  initial begin
    int r;
    int bound;
    logic h;
    reset = 1'b1; req = 2'b00; hold = 1'b0; lv0 = '0; lv1 = '0;
    #2 reset = 1'b0;
    #1 check_zero("reset_async_start");
    cycr(1'b0, 2'b00, 1'b0, 0, 0);
    cycr(1'b0, 2'b00, 1'b0, 0, 0);

    // Single requester, load 3
    for (int i = 0; i < 7; i++) cyc(2'b01, 1'b0, 3, 0);
    cyc(2'b00, 1'b0, 3, 0);
    cyc(2'b00, 1'b0, 3, 0);

    // Both requesting from reset release
    cycr(1'b0, 2'b00, 1'b0, 1, 2);
    for (int i = 0; i < 14; i++) cyc(2'b11, 1'b0, 1, 2);
    cyc(2'b00, 1'b0, 1, 2);
    cyc(2'b00, 1'b0, 1, 2);

    // Zero load on requester 1
    for (int i = 0; i < 4; i++) cyc(2'b10, 1'b0, 0, 0);
    cyc(2'b00, 1'b0, 0, 0);
    cyc(2'b00, 1'b0, 0, 0);

    // Hold for three cycles at count 3
    for (int i = 0; i < 3; i++) cyc(2'b01, 1'b0, 5, 0);
    for (int i = 0; i < 3; i++) cyc(2'b01, 1'b1, 5, 0);
    for (int i = 0; i < 6; i++) cyc(2'b01, 1'b0, 5, 0);
    cyc(2'b00, 1'b0, 5, 0);

    // Abandon at count 4 with requester 1 pending
    for (int i = 0; i < 5; i++) cyc(2'b01, 1'b0, 8, 3);
    for (int i = 0; i < 8; i++) cyc(2'b10, 1'b0, 8, 3);
    for (int i = 0; i < 6; i++) cyc(2'b11, 1'b0, 1, 1);
    cyc(2'b00, 1'b0, 0, 0);

    // Asynchronous reset mid-count at count 2
    bound = 0;
    cyc(2'b01, 1'b0, 4, 0);
    while (!(m_owner == 0 && m_cnt == 2) && bound < 20) begin
      cyc(2'b01, 1'b0, 4, 0);
      bound++;
    end
    checks++;
    if (bound >= 20) begin
      errors++;
      $display("FAIL mid_reset_setup got bound=%0d want below 20", bound);
    end
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check_zero("reset_async_mid");
    cycr(1'b0, 2'b01, 1'b0, 4, 0);
    for (int i = 0; i < 10; i++) cyc(2'b11, 1'b0, 5, 6);

    // Randomized traffic
    r = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) r = $urandom_range(3);
      h = ($urandom_range(3) == 0);
      cyc(r[1:0], h,
          ($urandom_range(15) == 0) ? 20 : int'($urandom_range(6)),
          ($urandom_range(15) == 0) ? 20 : int'($urandom_range(6)));
    end
    for (int i = 0; i < 3; i++) cyc(2'b00, 1'b0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
